// File: rtl/jelly_bean_dispatcher.sv
// Order FIFO plus WRITE/READ sequencer driving the jelly_bean_if master signals.
// Optional build macro: JB_DISPATCH_DROP_NOFLAVOR_EN (discard NO_FLAVOR orders, count them in drop_cnt).
module jelly_bean_dispatcher #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_flavor,
  input  logic [1:0]       in_color,
  input  logic             in_sugar_free,
  input  logic             in_sour,
  output logic [1:0]       jb_command,
  output logic [2:0]       jb_flavor,
  output logic [1:0]       jb_color,
  output logic             jb_sugar_free,
  output logic             jb_sour,
  input  logic [1:0]       jb_taste,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_flavor,
  output logic [1:0]       out_taste,
  output logic [CNT_W-1:0] count
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    CMD_NO_OP = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} state_e;

  typedef struct packed {
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
  } order_t;

  order_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             push;
  logic             pop;
  order_t           in_order;

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  order_t     bus_q, bus_d;
  logic       out_valid_d;
  logic [2:0] out_flavor_d;
  logic [1:0] out_taste_d;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign in_order = {in_flavor, in_color, in_sugar_free, in_sour};

`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
  assign push = accept && (in_flavor != 3'd0);
`else
  assign push = accept;
`endif

  // NOTE: the queue storage is not reset; a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_order;
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and next-output logic; the bus is driven straight from registers.
  // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cmd_d        = CMD_NO_OP;
    bus_d        = '0;
    out_valid_d  = out_valid;
    out_flavor_d = out_flavor;
    out_taste_d  = out_taste;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          bus_d   = mem[rd_ptr];
          cmd_d   = CMD_WRITE;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus_d   = bus_q;
        cmd_d   = CMD_READ;
        state_d = ST_READ;
      end
      ST_READ: begin
        // The taster's answer for this order is valid during the READ cycle.
        out_valid_d  = 1'b1;
        out_flavor_d = bus_q.flavor;
        out_taste_d  = jb_taste;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NO_OP;
      bus_q      <= '0;
      out_valid  <= 1'b0;
      out_flavor <= '0;
      out_taste  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bus_q      <= bus_d;
      out_valid  <= out_valid_d;
      out_flavor <= out_flavor_d;
      out_taste  <= out_taste_d;
    end
  end

  assign jb_command    = cmd_q;
  assign jb_flavor     = bus_q.flavor;
  assign jb_color      = bus_q.color;
  assign jb_sugar_free = bus_q.sugar_free;
  assign jb_sour       = bus_q.sour;

`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && (in_flavor == 3'd0) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jelly_bean_dispatcher.sv
// Bench for jelly_bean_dispatcher: directed latency/back-pressure/reset cases plus randomized
// traffic against an order-queue reference model; honours JB_DISPATCH_DROP_NOFLAVOR_EN.
module tb_jelly_bean_dispatcher;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_flavor;
  logic [1:0]       in_color;
  logic             in_sugar_free;
  logic             in_sour;
  logic [1:0]       jb_command;
  logic [2:0]       jb_flavor;
  logic [1:0]       jb_color;
  logic             jb_sugar_free;
  logic             jb_sour;
  logic [1:0]       jb_taste;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_flavor;
  logic [1:0]       out_taste;
  logic [CNT_W-1:0] count;
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
  logic [7:0]       drop_cnt;
`endif

  jelly_bean_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flavor     (in_flavor),
    .in_color      (in_color),
    .in_sugar_free (in_sugar_free),
    .in_sour       (in_sour),
    .jb_command    (jb_command),
    .jb_flavor     (jb_flavor),
    .jb_color      (jb_color),
    .jb_sugar_free (jb_sugar_free),
    .jb_sour       (jb_sour),
    .jb_taste      (jb_taste),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flavor    (out_flavor),
    .out_taste     (out_taste),
    .count         (count)
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Taster stand-in: a WRITE with a real flavor updates the taste, NO_FLAVOR holds it.
  always @(posedge clk or posedge rst) begin
    if (rst) jb_taste <= 2'd0;
    else if (jb_command == 2'd2 && jb_flavor != 3'd0)
      jb_taste <= (jb_flavor == 3'd4 && jb_sour) ? 2'd2 : 2'd1;
  end

  typedef struct packed {
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
  } ord_t;

  int         checks    = 0;
  int         failures  = 0;
  int         n_results = 0;
  int         exp_drop  = 0;
  int         max_count = 0;
  ord_t       exp_q [$];
  logic [1:0] last_taste = 2'd0;
  logic [1:0] prev_cmd   = 2'd0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [1:0] taste_of(input ord_t o, input logic [1:0] last);
    if (o.flavor == 3'd0) return last;
    return (o.flavor == 3'd4 && o.sour) ? 2'd2 : 2'd1;
  endfunction

  // Reference model: accepted orders are queued; the oldest one is the one on the bus,
  // and results come back strictly in acceptance order.
  task automatic monitor();
    ord_t o;
    logic [1:0] t;
    if (rst) begin
      exp_q.delete();
      last_taste = 2'd0;
      exp_drop   = 0;
      prev_cmd   = 2'd0;
      return;
    end
    if (int'(count) > max_count) max_count = int'(count);
    if (jb_command == 2'd2 || jb_command == 2'd1) begin
      if (exp_q.size() == 0) check("bus_order_known", 0, 1);
      else begin
        check("bus_flavor", jb_flavor, exp_q[0].flavor);
        check("bus_color", jb_color, exp_q[0].color);
        check("bus_sugar_free", jb_sugar_free, exp_q[0].sugar_free);
        check("bus_sour", jb_sour, exp_q[0].sour);
      end
    end else begin
      check("bus_cmd_noop", jb_command, 0);
      check("bus_idle_fields", {jb_flavor, jb_color, jb_sugar_free, jb_sour}, 0);
    end
    if (prev_cmd == 2'd2) check("write_then_read", jb_command, 1);
    prev_cmd = jb_command;
    if (in_valid && in_ready) begin
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
      if (in_flavor == 3'd0) begin
        if (exp_drop < 255) exp_drop++;
      end else
`endif
      exp_q.push_back(ord_t'({in_flavor, in_color, in_sugar_free, in_sour}));
    end
    if (out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        o = exp_q.pop_front();
        t = taste_of(o, last_taste);
        last_taste = t;
        check("result_flavor", out_flavor, o.flavor);
        check("result_taste", out_taste, t);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_order(input logic [2:0] fl, input logic [1:0] co, input logic sf, input logic sr);
    in_flavor     = fl;
    in_color      = co;
    in_sugar_free = sf;
    in_sour       = sr;
  endtask

  task automatic push_order(input logic [2:0] fl, input logic [1:0] co, input logic sf, input logic sr);
    int n = 0;
    drive_order(fl, co, sf, sr);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n = 0;
    while (n_results < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_order(3'd0, 2'd0, 1'b0, 1'b0);
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flavor", out_flavor, 0);
    check("rst_out_taste", out_taste, 0);
    check("rst_count", count, 0);
    check("rst_jb_command", jb_command, 0);
    check("rst_jb_fields", {jb_flavor, jb_color, jb_sugar_free, jb_sour}, 0);
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
  endtask

  // One order into an empty, idle dispatcher with out_ready high; checks exact cycle timing.
  task automatic single_order(input logic [2:0] fl, input logic sr, input logic [1:0] exp_taste);
    logic [1:0] cmds [4];
    logic [1:0] exp_cmds [4];
    exp_cmds  = '{2'd0, 2'd2, 2'd1, 2'd0};
    out_ready = 1'b1;
    drive_order(fl, 2'd1, 1'b0, sr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("so_count_n1", count, 1);
    for (int c = 0; c < 4; c++) begin
      cmds[c] = jb_command;
      if (c == 1) begin
        check("so_write_flavor", jb_flavor, fl);
        check("so_write_sour", jb_sour, sr);
      end
      if (c == 3) begin
        check("so_out_valid", out_valid, 1);
        check("so_out_flavor", out_flavor, fl);
        check("so_out_taste", out_taste, exp_taste);
      end
      tick();
    end
    for (int c = 0; c < 4; c++) check("so_cmd_seq", cmds[c], exp_cmds[c]);
    check("so_out_valid_cleared", out_valid, 0);
  endtask

  initial begin
    int base;
    int exp_n;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_order(3'd0, 2'd0, 1'b0, 1'b0);
    #1;
    apply_reset();

    single_order(3'd4, 1'b1, 2'd2);
    single_order(3'd1, 1'b0, 2'd1);

    // Five back-to-back orders against a stalled consumer.
    base = n_results;
    out_ready = 1'b0;
    push_order(3'd4, 2'd0, 1'b0, 1'b1);
    push_order(3'd1, 2'd1, 1'b1, 1'b0);
    push_order(3'd2, 2'd2, 1'b0, 1'b0);
    push_order(3'd3, 2'd3, 1'b1, 1'b1);
    push_order(3'd1, 2'd0, 1'b0, 1'b1);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    drive_order(3'd2, 2'd1, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_in_ready", in_ready, 0);
      check("full_hold_count", count, 4);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_out_flavor", out_flavor, 4);
      check("stall_out_taste", out_taste, 2);
      check("stall_bus_noop", jb_command, 0);
    end
    out_ready = 1'b1;
    wait_results(base + 5, 60);
    repeat (6) tick();
    check("burst_result_count", n_results - base, 5);
    check("burst_no_loss", exp_q.size(), 0);

    // Reset during READ with two orders still queued.
    push_order(3'd2, 2'd0, 1'b0, 1'b0);
    push_order(3'd3, 2'd1, 1'b0, 1'b1);
    push_order(3'd4, 2'd2, 1'b1, 1'b1);
    check("mid_in_read", jb_command, 1);
    check("mid_count", count, 2);
    base = n_results;
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cmd", jb_command, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) tick();
    check("mid_after_count", count, 0);
    check("mid_after_no_result", n_results - base, 0);

    // NO_FLAVOR followed by BLUEBERRY.
    base      = n_results;
    max_count = 0;
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    push_order(3'd0, 2'd0, 1'b0, 1'b0);
    push_order(3'd2, 2'd1, 1'b0, 1'b0);
    wait_results(base + exp_n, 30);
    repeat (6) tick();
    check("noflavor_results", n_results - base, exp_n);
    check("noflavor_peak_count", max_count, 1);
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
    check("noflavor_drop_cnt", drop_cnt, 1);
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      drive_order(3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || count != 0); i++) tick();
    repeat (4) tick();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);
    check("random_saw_results", (n_results > 50), 1);
`ifdef JB_DISPATCH_DROP_NOFLAVOR_EN
    check("random_drop_cnt", drop_cnt, exp_drop);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
